// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sound-effect arbiter in front of the APU.
// Optional preemption of lower-priority effects: define SFX_PREEMPT_EN.
module sfx_scheduler #(
  parameter int DUR_EAT    = 8,
  parameter int DUR_HIT    = 4,
  parameter int DUR_DIE    = 30,
  parameter int GAP_FRAMES = 1,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       req_eat,
  input  logic       req_hit,
  input  logic       req_die,
  output logic       saw_trigger,
  output logic       square_trigger,
  output logic       noise_trigger,
  output logic [1:0] active_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam logic [1:0] ID_NONE = 2'b00;
  localparam logic [1:0] ID_EAT  = 2'b01;
  localparam logic [1:0] ID_HIT  = 2'b10;
  localparam logic [1:0] ID_DIE  = 2'b11;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // A zero duration still plays for one frame.
  localparam logic [CNT_W-1:0] LEN_EAT =
    (DUR_EAT == 0) ? ONE : CNT_W'(DUR_EAT);
  localparam logic [CNT_W-1:0] LEN_HIT =
    (DUR_HIT == 0) ? ONE : CNT_W'(DUR_HIT);
  localparam logic [CNT_W-1:0] LEN_DIE =
    (DUR_DIE == 0) ? ONE : CNT_W'(DUR_DIE);
  localparam logic [CNT_W-1:0] LEN_GAP =
    CNT_W'(GAP_FRAMES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       pend_q;
  logic [2:0]       pend_d;
  logic [1:0]       act_q;
  logic [1:0]       act_d;

  logic [2:0]       req_v;
  logic [2:0]       play_mask;
  logic [2:0]       set_v;
  logic [2:0]       pend_all;
  logic [2:0]       top_bit;
  logic [2:0]       keep;
  logic [1:0]       top_id;
  logic             cnt_last;
  logic             preempt;

  function automatic logic [2:0] id_bit(
    input logic [1:0] id
  );
    case (id)
      ID_EAT:  id_bit = 3'b001;
      ID_HIT:  id_bit = 3'b010;
      ID_DIE:  id_bit = 3'b100;
      default: id_bit = 3'b000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] id_len(
    input logic [1:0] id
  );
    case (id)
      ID_EAT:  id_len = LEN_EAT;
      ID_HIT:  id_len = LEN_HIT;
      ID_DIE:  id_len = LEN_DIE;
      default: id_len = ONE;
    endcase
  endfunction

  assign req_v = {req_die, req_hit, req_eat};

  // Re-requesting the effect that is already playing is dropped.
  assign play_mask = (state_q == PLAY) ?
                     id_bit(act_q) : 3'b000;

  assign set_v    = req_v & ~play_mask;
  assign pend_all = pend_q | set_v;
  assign cnt_last = (cnt_q <= ONE);

  always_comb begin
    top_id = ID_NONE;
    unique case (1'b1)
      pend_all[2]:
        top_id = ID_DIE;
      pend_all[1] && !pend_all[2]:
        top_id = ID_HIT;
      pend_all[0] && (pend_all[2:1] == 2'b00):
        top_id = ID_EAT;
      default:
        top_id = ID_NONE;
    endcase
  end

  assign top_bit = id_bit(top_id);

  // Old request plus a fresh pulse on the granted bit: serve it again.
  assign keep = pend_q & set_v & top_bit;

`ifdef SFX_PREEMPT_EN
  assign preempt = (state_q == PLAY) && frame_end &&
                   (top_id > act_q);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_all;
    unique case (state_q)
      IDLE: begin
        if (top_id != ID_NONE) begin
          state_d = PLAY;
          act_d   = top_id;
          cnt_d   = id_len(top_id);
          pend_d  = (pend_all & ~top_bit) | keep;
        end
      end
      PLAY: begin
        if (preempt) begin
          act_d  = top_id;
          cnt_d  = id_len(top_id);
          pend_d = (pend_all & ~top_bit) | keep;
        end else if (frame_end) begin
          if (cnt_last) begin
            act_d = ID_NONE;
            if (GAP_FRAMES == 0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = GAP;
              cnt_d   = LEN_GAP;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      GAP: begin
        if (frame_end) begin
          if (cnt_last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        act_d   = ID_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pend_q         <= 3'b000;
      act_q          <= ID_NONE;
      saw_trigger    <= 1'b0;
      square_trigger <= 1'b0;
      noise_trigger  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      act_q          <= act_d;
      saw_trigger    <= (state_d == PLAY) &&
                        (act_d == ID_EAT);
      square_trigger <= (state_d == PLAY) &&
                        (act_d == ID_HIT);
      noise_trigger  <= (state_d == PLAY) &&
                        (act_d == ID_DIE);
      busy           <= (state_d != IDLE);
    end
  end

  assign active_id = act_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: directed steps with a segment scoreboard.
// Segments (effect or gap) are checked for identity and frame length.
module tb_sfx_scheduler;

  localparam int FRAME = 20;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EAT  = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_DIE  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  typedef struct {
    logic [2:0] code;
    int         frames;
  } seg_t;

  logic       clk;
  logic       reset;
  logic       frame_end;
  logic       req_eat;
  logic       req_hit;
  logic       req_die;
  logic       saw_trigger;
  logic       square_trigger;
  logic       noise_trigger;
  logic [1:0] active_id;
  logic       busy;

  int   n_tests;
  int   n_fail;
  int   fcnt;
  bit   mon_en;
  seg_t sbq[$];

  logic [2:0] cur;
  int         cur_frames;

  sfx_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .frame_end      (frame_end),
    .req_eat        (req_eat),
    .req_hit        (req_hit),
    .req_die        (req_die),
    .saw_trigger    (saw_trigger),
    .square_trigger (square_trigger),
    .noise_trigger  (noise_trigger),
    .active_id      (active_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] seg_of();
    if (!busy) return S_IDLE;
    if (active_id == 2'b00) return S_GAP;
    return {1'b0, active_id};
  endfunction

  function automatic logic [2:0] trig_exp(
    input logic [1:0] id
  );
    case (id)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Monitor first, then advance the frame generator.
  always @(negedge clk) begin
    logic [2:0] seg;
    seg_t       e;
    if (!mon_en) begin
      cur        = S_IDLE;
      cur_frames = 0;
    end else begin
      seg = seg_of();
      if (cur != S_IDLE && frame_end)
        cur_frames++;
      if (seg != cur) begin
        if (cur != S_IDLE) begin
          n_tests++;
          assert (sbq.size() != 0) else begin
            n_fail++;
            $error("FAIL seg_unexpected: observed %0d/%0d expected none",
                   cur, cur_frames);
          end
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("seg_code", 32'(cur), 32'(e.code));
            chk("seg_frames", cur_frames, e.frames);
          end
        end
        cur        = seg;
        cur_frames = 0;
      end
      chk("trig_onehot",
          {saw_trigger, square_trigger, noise_trigger},
          32'(trig_exp(active_id)));
    end
    fcnt      = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
    frame_end = (fcnt == FRAME - 1);
  end

  task automatic push(input logic [2:0] c, input int f);
    seg_t e;
    e.code   = c;
    e.frames = f;
    sbq.push_back(e);
  endtask

  task automatic pulse(input logic [2:0] r);
    {req_die, req_hit, req_eat} = r;
    @(posedge clk);
    #1;
    {req_die, req_hit, req_eat} = 3'b000;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (frame_end) k++;
    end
    #1;
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    while ((sbq.size() != 0 || busy) && c < bound) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("done_timeout", 32'(c < bound), 32'd1);
  endtask

  task automatic wait_until_busy_low(input int bound);
    int c = 0;
    while (busy && c < bound) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("busy_low_timeout", 32'(c < bound), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_tests   = 0;
    n_fail    = 0;
    fcnt      = 0;
    frame_end = 1'b0;
    mon_en    = 1'b0;
    reset     = 1'b1;
    req_eat   = 1'b0;
    req_hit   = 1'b0;
    req_die   = 1'b1;

    @(posedge clk);
    #1;
    chk("rst_out", {saw_trigger, square_trigger,
        noise_trigger, active_id, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_out2", {saw_trigger, square_trigger,
        noise_trigger, active_id, busy}, 32'd0);
    reset   = 1'b0;
    req_die = 1'b0;
    mon_en  = 1'b1;
    wait_frames(5);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_idle_id", 32'(active_id), 32'd0);

    // Single eat
    push(S_EAT, 8);
    push(S_GAP, 1);
    pulse(3'b001);
    chk("eat_saw", 32'(saw_trigger), 32'd1);
    chk("eat_id", 32'(active_id), 32'd1);
    chk("eat_busy", 32'(busy), 32'd1);
    wait_done(1000);
    chk("eat_id_end", 32'(active_id), 32'd0);

    // Simultaneous requests
    push(S_DIE, 30);
    push(S_GAP, 1);
    push(S_HIT, 4);
    push(S_GAP, 1);
    push(S_EAT, 8);
    push(S_GAP, 1);
    pulse(3'b111);
    chk("all_noise", 32'(noise_trigger), 32'd1);
    chk("all_id", 32'(active_id), 32'd3);
    wait_done(5000);

    // Drop rule, then request during gap
    push(S_HIT, 4);
    push(S_GAP, 1);
    pulse(3'b010);
    chk("hit_square", 32'(square_trigger), 32'd1);
    wait_frames(1);
    pulse(3'b010);
    c = 0;
    while (active_id != 2'b00 && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("hit_gap_reach", 32'(c < 1000), 32'd1);
    chk("hit_gap_busy", 32'(busy), 32'd1);
    push(S_EAT, 8);
    push(S_GAP, 1);
    pulse(3'b001);
    wait_until_busy_low(1000);
    @(posedge clk);
    #1;
    chk("gap_then_saw", 32'(saw_trigger), 32'd1);
    wait_done(1000);

    // Higher-priority request during eat
`ifdef SFX_PREEMPT_EN
    push(S_EAT, 3);
    push(S_DIE, 30);
    push(S_GAP, 1);
`else
    push(S_EAT, 8);
    push(S_GAP, 1);
    push(S_DIE, 30);
    push(S_GAP, 1);
`endif
    pulse(3'b001);
    wait_frames(2);
    pulse(3'b100);
    wait_frames(1);
`ifdef SFX_PREEMPT_EN
    chk("pre_noise", 32'(noise_trigger), 32'd1);
    chk("pre_saw", 32'(saw_trigger), 32'd0);
`else
    chk("nopre_saw", 32'(saw_trigger), 32'd1);
    chk("nopre_noise", 32'(noise_trigger), 32'd0);
`endif
    wait_done(5000);

    // Reset during noise with eat and hit pending
    mon_en = 1'b0;
    pulse(3'b100);
    wait_frames(2);
    pulse(3'b011);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out", {saw_trigger, square_trigger,
        noise_trigger, active_id, busy}, 32'd0);
    reset = 1'b0;
    sbq.delete();
    mon_en = 1'b1;
    wait_frames(5);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_id", 32'(active_id), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
- Arbitrates game sound-effect requests (sheep eaten, dragon hit, player death) onto the single AudioProcessingUnit.
- Sits between APU_trigger and the APU in the top level.
- Latches request pulses and grants one effect at a time by fixed priority.
- Holds the granted channel's trigger for a programmed number of frames, then inserts a silence gap.

Parameters:
- DUR_EAT, 8, frames the saw channel is held for an eat effect.
- DUR_HIT, 4, frames the square channel is held for a hit effect.
- DUR_DIE, 30, frames the noise channel is held for a death effect.
- GAP_FRAMES, 1, silent frames inserted after each effect (0 = none).
- CNT_W, 6, frame-counter width; every DUR_* and GAP_FRAMES must be < 2^CNT_W.

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- reset  in  1  synchronous, active-high reset
- frame_end  in  1  one-cycle pulse per video frame, from sync_generator
- req_eat  in  1  eat-effect request pulse
- req_hit  in  1  hit-effect request pulse
- req_die  in  1  die-effect request pulse
- saw_trigger  out  1  to APU saw_trigger; high while the eat effect plays
- square_trigger  out  1  to APU square_trigger; high while the hit effect plays
- noise_trigger  out  1  to APU noise_trigger; high while the die effect plays
- active_id  out  2  playing effect: 00 none, 01 eat, 10 hit, 11 die
- busy  out  1  high in PLAY or GAP

Behaviour:
- Reset (synchronous, active-high): all outputs 0, pending bits cleared, counter 0, state IDLE. Reset dominates any same-cycle request or frame_end.
- Pending register pend[2:0] = {die, hit, eat}.
  - A request pulse sets its bit on the next edge.
  - A request for the channel currently in PLAY is dropped, not pended.
  - If a bit's set and its clear (grant) happen in the same cycle, set wins and the request is served again later.
- Priority: die > hit > eat.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If pend != 0 (including bits set this cycle), grant the highest-priority bit: clear it, load cnt = DUR_x, enter PLAY.
  - The trigger output and active_id assert on the edge the grant is taken, i.e. 1 cycle after the request pulse when IDLE.
- PLAY:
  - Exactly one trigger output is high, matching active_id.
  - cnt decrements only on frame_end.
  - On frame_end with cnt == 1, the trigger drops. Next state is GAP with cnt = GAP_FRAMES, or IDLE if GAP_FRAMES == 0.
  - A requested duration of 0 is treated as 1.
- GAP:
  - All triggers low, active_id = 00, busy = 1.
  - cnt decrements on frame_end; leave to IDLE on frame_end with cnt == 1.
  - Requests keep latching into pend.
- Effect length in frames is exact: the first partial frame is counted as frame 1 and termination is aligned to frame_end.
- Outputs are registered; at most one trigger is high at any time.
- Simultaneous requests in one cycle: all pend bits set; served one after another in priority order, each followed by the gap.

Optional Feature:
- Macro SFX_PREEMPT_EN.
- Defined:
  - In PLAY, a pending request of strictly higher priority than active_id aborts the current effect on the next frame_end.
  - The old trigger drops and the new trigger rises on that same edge, with cnt = new DUR_x. The gap is skipped.
  - The aborted effect is not re-queued.
- Undefined: no preemption; the current effect always runs to completion plus the gap.

Test Plan (default parameters):
- Reset: assert reset with req_die high → all outputs 0 and busy 0; after release with no requests, the block stays IDLE for 5 frames.
- Single eat: req_eat pulse while IDLE → saw_trigger high 1 cycle later; it falls on the 8th frame_end; busy falls on the 9th frame_end; active_id returns to 00.
- Simultaneous requests: req_eat, req_hit and req_die in the same cycle → noise for 30 frames, 1-frame gap, square for 4 frames, 1-frame gap, saw for 8 frames. Never more than one trigger high.
- Drop rule: req_hit during hit PLAY → ignored, square runs exactly 4 frames, then IDLE. req_eat during hit GAP → saw starts on the cycle after the gap ends.
- Reset mid-operation: reset during noise PLAY with pend = 011 → next cycle all outputs 0; after release nothing plays.
- SFX_PREEMPT_EN: req_die 2 frames into eat PLAY → saw drops and noise rises at the next frame_end edge; noise lasts 30 frames; eat is not replayed. Without the macro: eat completes 8 frames, gap, then noise.
